spi_dac_sequencer: RTL
======================

SPI_DAC_SEQUENCER -- requirements
Module: spi_dac_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2: CLOCK cycles per SCK half-period; legal range >=1.
REQ-002 Parameter DATA_WIDTH, default 12: DAC code width; legal range 1..16.
REQ-003 Parameter NUM_CHANNELS, default 4: channels swept in auto mode; legal range 1..16.
REQ-004 Parameter CLR_CYCLES, default 4: DAC_CLR low-pulse length in CLOCK cycles; legal range >=1.
REQ-005 One clock; reset is asynchronous and active-low. Ports: CLOCK in 1, system clock; RESET in 1, async active-low reset.
REQ-006 START in 1: single-frame request; CMD in 4: DAC command; ADDR in 4: DAC address; DATA in DATA_WIDTH: DAC code.
REQ-007 AUTO in 1: auto-scan enable; CH_DATA in NUM_CHANNELS*DATA_WIDTH: channel k code at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 CLEAR in 1: request DAC_CLR pulse; SPI_MISO in 1: DAC serial out.
REQ-009 SPI_SCK out 1; SPI_MOSI out 1; DAC_CS out 1, active-low; DAC_CLR out 1, active-low.
REQ-010 BUSY out 1: operation in progress; DONE out 1: one-cycle completion pulse; ECHO out 32: last frame captured from MISO; CHANNEL out 4: current auto-scan index.

Function
REQ-011 Frame SHALL be 32 bits, MSB first: {8'h00, CMD, ADDR, DATA left-aligned in 16 bits, unused low data bits 0}.
REQ-012 States: IDLE, CLR, SHIFT_LO, SHIFT_HI, TAIL, GAP; requests SHALL be sampled only in IDLE.
REQ-013 IDLE priority, same cycle: CLEAR > START > AUTO; lower-priority requests SHALL be ignored that cycle.
REQ-014 CLEAR accepted -> CLR: DAC_CLR low exactly CLR_CYCLES cycles, BUSY high; then DONE pulse, return to IDLE; no SPI activity.
REQ-015 START accepted at cycle 0 -> CMD/ADDR/DATA latched at cycle 0; DAC_CS low from cycle 1; later input changes SHALL not affect the frame.
REQ-016 SHIFT_LO: SCK low CLK_DIV cycles, MOSI driven with the current bit from its first cycle; SHIFT_HI: SCK high CLK_DIV cycles.
REQ-017 SPI_MISO SHALL be sampled on each SCK rising edge into a 32-bit shift register, MSB first.
REQ-018 After the 32nd SHIFT_HI -> TAIL: SCK low, CS low, CLK_DIV cycles; CS low total = 65*CLK_DIV cycles.
REQ-019 GAP: CS high, SCK low, MOSI 0, CLK_DIV cycles; ECHO SHALL update on GAP entry; after GAP -> DONE pulse, BUSY low, IDLE, same cycle.
REQ-020 START held high SHALL produce back-to-back frames separated by GAP plus one IDLE cycle.
REQ-021 AUTO high in IDLE (no CLEAR/START) -> frame with CMD=4'b0011, ADDR=CHANNEL, DATA=CH_DATA slice for CHANNEL, latched at frame start.
REQ-022 After each auto frame CHANNEL SHALL increment, wrapping NUM_CHANNELS-1 -> 0; DONE pulses per frame.
REQ-023 AUTO deasserted mid-frame SHALL complete the current frame, then idle; CHANNEL SHALL hold its value.
REQ-024 BUSY SHALL be high in every state except IDLE.
REQ-025 Bit counter SHALL be 6 bits; divider counter SHALL be ceil(log2(CLK_DIV+1)) bits.

Reset
REQ-026 RESET low SHALL force immediately: SPI_SCK 0, SPI_MOSI 0, DAC_CS 1, DAC_CLR 0, BUSY 0, DONE 0, ECHO 0, CHANNEL 0, state IDLE.
REQ-027 DAC_CLR SHALL rise on the first CLOCK edge after RESET release.
REQ-028 RESET asserted mid-frame SHALL abort it: CS high immediately, no DONE, ECHO cleared.

Verification
REQ-029 CLK_DIV=2, START with CMD=3, ADDR=0, DATA=12'h800 -> MOSI stream 32'h0030_8000, 32 SCK rising edges, CS low 130 cycles, one DONE.
REQ-030 SPI_MISO driven with 32'hA5A5_0F0F, bit-aligned to SCK rising edges -> ECHO=32'hA5A5_0F0F at DONE.
REQ-031 NUM_CHANNELS=4, AUTO=1, CH_DATA codes 1,2,3,4 -> frames 32'h0030_0010, 0031_0020, 0032_0030, 0033_0040, then CHANNEL wraps to 0.
REQ-032 CLEAR and START together in IDLE -> DAC_CLR low CLR_CYCLES=4 cycles, no CS activity, START ignored.
REQ-033 RESET low at bit 10 of a frame -> CS=1, SCK=0 immediately; no DONE; next START yields a full correct frame.
REQ-034 DATA_WIDTH=8, DATA=8'hFF, CMD=3, ADDR=1 -> MOSI stream 32'h0031_FF00.

Source files
------------

// File: rtl/spi_dac_sequencer.sv
// rtl/spi_dac_sequencer.sv - SPI DAC frame sequencer with DAC_CLR pulse and auto channel scan
module spi_dac_sequencer #(
    parameter int CLK_DIV      = 2,
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_CHANNELS = 4,
    parameter int CLR_CYCLES   = 4
) (
    input  logic                               CLOCK,
    input  logic                               RESET,
    input  logic                               START,
    input  logic [3:0]                         CMD,
    input  logic [3:0]                         ADDR,
    input  logic [DATA_WIDTH-1:0]              DATA,
    input  logic                               AUTO,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] CH_DATA,
    input  logic                               CLEAR,
    input  logic                               SPI_MISO,
    output logic                               SPI_SCK,
    output logic                               SPI_MOSI,
    output logic                               DAC_CS,
    output logic                               DAC_CLR,
    output logic                               BUSY,
    output logic                               DONE,
    output logic [31:0]                        ECHO,
    output logic [3:0]                         CHANNEL
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_TAIL,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [31:0]        tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic [31:0]        echo_q, echo_d;
    logic [3:0]         chan_q, chan_d;
    logic               auto_q, auto_d;
    logic               done_q, done_d;
    logic               dac_clr_q;
    logic               div_last;

    // Data is left-aligned into the 16-bit data field; unused low bits stay zero.
    function automatic logic [31:0] make_frame(input logic [3:0] c, input logic [3:0] a,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [15:0] d16;
        d16 = 16'(d) << (16 - DATA_WIDTH);
        return {8'h00, c, a, d16};
    endfunction

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        clr_d   = clr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        echo_d  = echo_q;
        chan_d  = chan_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (CLEAR) begin
                    clr_d   = '0;
                    state_d = S_CLR;
                end else if (START) begin
                    tx_d    = make_frame(CMD, ADDR, DATA);
                    auto_d  = 1'b0;
                    state_d = S_SHIFT_LO;
                end else if (AUTO) begin
                    tx_d    = make_frame(4'b0011, chan_q,
                                         CH_DATA[int'(chan_q) * DATA_WIDTH +: DATA_WIDTH]);
                    auto_d  = 1'b1;
                    state_d = S_SHIFT_LO;
                end
            end
            S_CLR: begin
                if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    clr_d = clr_q + CLR_W'(1);
                end
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    // This edge is the SCK rising edge, so MISO is captured here.
                    div_d   = '0;
                    rx_d    = {rx_q[30:0], SPI_MISO};
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    tx_d  = {tx_q[30:0], 1'b0};
                    if (bit_q == 6'd31) begin
                        state_d = S_TAIL;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_TAIL: begin
                if (div_last) begin
                    div_d   = '0;
                    echo_d  = rx_q;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (div_last) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (auto_q) begin
                        chan_d = (chan_q == 4'(NUM_CHANNELS - 1)) ? 4'd0 : chan_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            clr_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            echo_q    <= '0;
            chan_q    <= '0;
            auto_q    <= 1'b0;
            done_q    <= 1'b0;
            dac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            clr_q     <= clr_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            echo_q    <= echo_d;
            chan_q    <= chan_d;
            auto_q    <= auto_d;
            done_q    <= done_d;
            dac_clr_q <= (state_d != S_CLR);
        end
    end

    assign SPI_SCK  = (state_q == S_SHIFT_HI);
    assign SPI_MOSI = ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)) ? tx_q[31] : 1'b0;
    assign DAC_CS   = !((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI) || (state_q == S_TAIL));
    assign DAC_CLR  = dac_clr_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign ECHO     = echo_q;
    assign CHANNEL  = chan_q;

endmodule
